sopc_run_ctrl: RTL and testbench

Synthesizable run controller for the minimal SOPC. It holds the CPU and its peripherals in reset for a programmable time after power-on or a soft-reset request, then releases N reset domains one by one. It counts run cycles and stops the run when the core signals halt or when a cycle budget expires. It is the hardware counterpart of the bench-level reset/stop sequencing and sits between the board clock/reset and the `openmips_min_sopc` reset inputs.

---
 rtl/sopc_run_ctrl_if.sv | 24 ++
 rtl/sopc_run_ctrl.sv | 102 ++++++++++
 tb/tb_sopc_run_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sopc_run_ctrl_if.sv
// Control/status bundle between the run controller and the SOPC it sequences.
// The controller side uses the master modport; the core/board side uses slave.
interface sopc_run_ctrl_if #(
    parameter int N_RST = 3,
    parameter int CNT_W = 16
);
    logic             soft_rst_i;
    logic             halt_i;
    logic [N_RST-1:0] rst_o;
    logic             running_o;
    logic             done_o;
    logic             timeout_o;
    logic [CNT_W-1:0] cycle_cnt_o;

    modport master (
        input  soft_rst_i, halt_i,
        output rst_o, running_o, done_o, timeout_o, cycle_cnt_o
    );

    modport slave (
        output soft_rst_i, halt_i,
        input  rst_o, running_o, done_o, timeout_o, cycle_cnt_o
    );
endinterface

// File: rtl/sopc_run_ctrl.sv
// Run controller: holds all reset domains, releases them one by one, then counts
// run cycles until the core halts or the cycle budget expires.
module sopc_run_ctrl #(
    parameter int N_RST          = 3,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGE_GAP      = 2,
    parameter int TIMEOUT_CYCLES = 300,
    parameter bit TIMEOUT_RST    = 1'b1,
    parameter int CNT_W          = 16
) (
    input logic             clk,
    input logic             rst,
    sopc_run_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cyc_q;
    logic [N_RST-1:0] rst_q;
    logic             running_q;
    logic             done_q;
    logic             timeout_q;

    // Domains release lowest bit first, so each release is a left shift of the mask.
    logic [N_RST-1:0] rst_shift_d;
    assign rst_shift_d = rst_q << 1;

    always_ff @(posedge clk) begin
        if (rst || bus.soft_rst_i) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            cyc_q     <= '0;
            rst_q     <= '1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_q <= '0;
                        rst_q <= rst_shift_d;
                        if (rst_shift_d == '0) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_q <= '0;
                        rst_q <= rst_shift_d;
                        if (rst_shift_d == '0) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    cyc_q <= cyc_q + CNT_W'(1);
                    // Halt takes precedence over budget expiry on the final cycle.
                    if (bus.halt_i) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        running_q <= 1'b0;
                    end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= S_TOUT;
                        timeout_q <= 1'b1;
                        running_q <= 1'b0;
                        if (TIMEOUT_RST) begin
                            rst_q <= '1;
                        end
                    end
                end
                S_DONE, S_TOUT: begin
                end
                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    assign bus.rst_o       = rst_q;
    assign bus.running_o   = running_q;
    assign bus.done_o      = done_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.cycle_cnt_o = cyc_q;
endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Scoreboard bench for sopc_run_ctrl: default instance (3 domains) and a
// single-domain instance share the same randomized stimulus.
module tb_sopc_run_ctrl;
    localparam int HOLD    = 10;
    localparam int GAP     = 2;
    localparam int TMO     = 300;
    localparam bit TMO_RST = 1'b1;

    typedef struct packed {
        logic [7:0]  rst;
        logic        running;
        logic        done;
        logic        timeout;
        logic [15:0] cnt;
    } exp_t;

    // e: clean edges since last (soft) reset; term: 0 none, 1 done, 2 timeout
    typedef struct {
        int e;
        int term;
        int cnt;
    } mstate_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sopc_run_ctrl_if #(.N_RST(3), .CNT_W(16)) ifa ();
    sopc_run_ctrl_if #(.N_RST(1), .CNT_W(16)) ifb ();

    sopc_run_ctrl #(.N_RST(3), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .TIMEOUT_CYCLES(TMO),
                    .TIMEOUT_RST(TMO_RST), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    sopc_run_ctrl #(.N_RST(1), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .TIMEOUT_CYCLES(TMO),
                    .TIMEOUT_RST(TMO_RST), .CNT_W(16))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    exp_t    qa[$];
    exp_t    qb[$];
    mstate_t ma;
    mstate_t mb;
    int      errors = 0;
    int      checks = 0;

    function automatic mstate_t step(mstate_t s, int n, bit r, bit sr, bit h);
        mstate_t ns;
        int trun;
        trun = HOLD + (n - 1) * GAP;
        ns = s;
        if (r || sr) begin
            ns.e = 0; ns.term = 0; ns.cnt = 0;
            return ns;
        end
        if (s.term == 0 && s.e >= trun) begin
            ns.cnt = s.cnt + 1;
            if (h) ns.term = 1;
            else if (ns.cnt == TMO) ns.term = 2;
        end
        if (ns.e < 100000) ns.e = s.e + 1;
        return ns;
    endfunction

    function automatic exp_t expect_of(mstate_t s, int n);
        exp_t x;
        int trun;
        trun = HOLD + (n - 1) * GAP;
        x = '0;
        for (int k = 0; k < n; k++) begin
            x.rst[k] = (s.e < HOLD + k * GAP) || (s.term == 2 && TMO_RST);
        end
        x.running = (s.term == 0) && (s.e >= trun);
        x.done    = (s.term == 1);
        x.timeout = (s.term == 2);
        x.cnt     = 16'(s.cnt);
        return x;
    endfunction

    // Drive inputs for the next rising edge and queue the responses it must produce.
    task automatic cycle(input bit r, input bit sr, input bit h);
        @(negedge clk);
        rst = r;
        ifa.soft_rst_i = sr; ifa.halt_i = h;
        ifb.soft_rst_i = sr; ifb.halt_i = h;
        ma = step(ma, 3, r, sr, h);
        mb = step(mb, 1, r, sr, h);
        qa.push_back(expect_of(ma, 3));
        qb.push_back(expect_of(mb, 1));
    endtask

    task automatic compare(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got rst=%b run=%b done=%b tmo=%b cnt=%0d, want rst=%b run=%b done=%b tmo=%b cnt=%0d",
                     name, $time, act.rst, act.running, act.done, act.timeout, act.cnt,
                     exp.rst, exp.running, exp.done, exp.timeout, exp.cnt);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop and compare after each edge.
    initial begin
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            act = '0;
            act.rst = 8'(ifa.rst_o); act.running = ifa.running_o; act.done = ifa.done_o;
            act.timeout = ifa.timeout_o; act.cnt = ifa.cycle_cnt_o;
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL n3_queue t=%0t: got empty scoreboard, want queued entry", $time);
            end else compare("n3_outputs", act, qa.pop_front());
            act = '0;
            act.rst = 8'(ifb.rst_o); act.running = ifb.running_o; act.done = ifb.done_o;
            act.timeout = ifb.timeout_o; act.cnt = ifb.cycle_cnt_o;
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL n1_queue t=%0t: got empty scoreboard, want queued entry", $time);
            end else compare("n1_outputs", act, qb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ma = '{0, 0, 0};
        mb = '{0, 0, 0};
        rst = 1'b1;
        ifa.soft_rst_i = 1'b0; ifa.halt_i = 1'b0;
        ifb.soft_rst_i = 1'b0; ifb.halt_i = 1'b0;
        qa.push_back(expect_of(ma, 3));
        qb.push_back(expect_of(mb, 1));

        // Power-on reset, then release and halt at cycle count 41.
        repeat (4) cycle(1, 0, 0);
        for (int i = 0; i < 200 && ma.cnt != 41; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        repeat (6) cycle(0, 0, 1'($urandom_range(0, 1)));

        // Reset and soft reset together while DONE.
        cycle(1, 1, 0);

        // Soft reset mid-release (mask 3'b110), then full sequence again.
        for (int i = 0; i < 50 && ma.e != 11; i++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (20) cycle(0, 0, 0);

        // Budget expiry with no halt.
        repeat (300) cycle(0, 0, 0);
        repeat (5) cycle(0, 0, 1'($urandom_range(0, 1)));

        // Halt on the final budget cycle.
        repeat (2) cycle(0, 1, 0);
        for (int i = 0; i < 400 && ma.cnt != 299; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        repeat (5) cycle(0, 0, 1'($urandom_range(0, 1)));

        // Randomized runs with occasional halts, soft resets and resets.
        for (int p = 0; p < 8; p++) begin
            repeat ($urandom_range(1, 3)) cycle(($urandom_range(0, 3) == 0), 1, 0);
            for (int i = 0; i < int'($urandom_range(5, 360)); i++) begin
                cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 79) == 0));
            end
        end

        @(posedge clk);
        #3;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", qa.size(), qb.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
